norm_adj_arbiter: RTL and testbench
===================================

Name: norm_adj_arbiter

Overview:
Shares one combinational exponent-adjust unit (exp_norm = exp_tmp − lz_count) among LANES vector lanes of the VFPU normalization stage. Each lane presents {exp_tmp, lz_count} with a valid/ready handshake. A round-robin arbiter grants one lane per cycle and drives the shared unit. The result is tagged with the lane index and buffered in a 2-entry output FIFO with its own valid/ready handshake to the rounding stage.

Parameters:
LANES, 4, number of requesting lanes (power of 2, ≥2)
LANE_W, 2, log2(LANES), width of lane tag
EXP_W, 10, exponent width (two's complement)
LZ_W, 7, leading-zero count width (unsigned)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  LANES  per-lane request valid
req_ready  output  LANES  per-lane accept; one-hot or zero
req_exp  input  LANES*EXP_W  per-lane exp_tmp; lane i at [i*EXP_W +: EXP_W]
req_lz  input  LANES*LZ_W  per-lane lz_count; lane i at [i*LZ_W +: LZ_W]
adj_exp_tmp  output  EXP_W  to shared adjust unit: granted lane's exp_tmp (0 when no grant)
adj_lz  output  LZ_W  to shared adjust unit: granted lane's lz_count (0 when no grant)
adj_exp_norm  input  EXP_W  from shared adjust unit, combinational result
res_valid  output  1  FIFO head valid
res_ready  input  1  downstream accept
res_lane  output  LANE_W  lane tag of head entry
res_exp  output  EXP_W  adjusted exponent of head entry
res_uf  output  1  head entry underflow flag = res_exp[EXP_W-1]

Behaviour:
- Reset (rst_n low, async): FIFO count=0, rd/wr pointers=0, rr_ptr=0; res_valid=0, res_lane=0, res_exp=0, res_uf=0. req_ready=0 while in reset, because the FIFO is treated as empty but grant is gated by reset.
- Handshakes: a transfer occurs when valid&ready are both high at a rising clk edge. Requesters must hold valid/data stable until accepted. res_* are held stable while res_valid=1 and res_ready=0.
- can_accept = (count<2) | (res_valid & res_ready). A simultaneous push and pop on a full FIFO is legal.
- Grant (combinational): if can_accept, select the first lane with req_valid set, scanning from rr_ptr upward modulo LANES. req_ready = one-hot of that lane, else 0. No grant is issued without valid.
- rr_ptr update: on a granted transfer to lane g, rr_ptr ← (g+1) mod LANES. Otherwise unchanged.
- Datapath: adj_exp_tmp/adj_lz are muxed from the granted lane. On a transfer, push {g, adj_exp_norm, adj_exp_norm[EXP_W-1]}.
- Arithmetic is owned by the shared unit: result = exp_tmp − zero-extended lz, modulo 2^EXP_W. There is no saturation.
- Latency: an accept in cycle N gives res_valid=1 with that entry in cycle N+1 if the FIFO was empty. Throughput is 1 result/cycle when res_ready=1.
- FIFO: 2 entries, in-order.
  - Push only: count+1.
  - Pop only: count−1.
  - Push and pop: count unchanged.
  - Pointers wrap modulo 2.
  - res_* are driven from entry[rd_ptr]; res_valid = (count≠0).
- Full: count=2 and res_ready=0 → req_ready=0 for all lanes; rr_ptr is frozen.
- Empty with res_ready=1: no pop occurs and there are no spurious results.
- Async reset mid-operation: FIFO contents are discarded. The accepted-but-undelivered results are lost; requesters re-issue.

Test Plan:
- Single lane: lane 2 valid with exp=10'd130, lz=7'd5 → req_ready=4'b0100 in the same cycle. Next cycle: res_valid=1, res_lane=2, res_exp=125, res_uf=0.
- Underflow: lane 0 with exp=10'd3, lz=7'd8 → res_exp=10'h3FB (−5), res_uf=1.
- Round-robin fairness: all 4 lanes valid continuously, res_ready=1, rr_ptr=0 → grants in order 0,1,2,3,0. One result per cycle with res_lane=0,1,2,3,0.
- Backpressure: res_ready=0, lanes 1 and 3 valid → two accepts (lane 1, then lane 3), then req_ready=0. Holding 5 cycles keeps res_lane=1 stable. Raising res_ready drains lane 1, then lane 3. Lane 1's re-request is granted in the cycle of the first pop (full with pop).
- Reset mid-operation: FIFO holds 2 entries; pulse rst_n low asynchronously → res_valid=0 and req_ready=0 immediately. After release, the first grant goes to the lowest valid lane because rr_ptr=0.
- Idle: no req_valid for 10 cycles → req_ready=0, adj_exp_tmp=0, adj_lz=0, res_valid stays 0, rr_ptr unchanged.

Source files
------------

// File: rtl/norm_adj_arbiter.sv
// Round-robin arbiter sharing one exponent-adjust unit among vector lanes,
// with a 2-entry lane-tagged result FIFO towards the rounding stage.
module norm_adj_arbiter #(
    parameter int LANES  = 4,
    parameter int LANE_W = 2,
    parameter int EXP_W  = 10,
    parameter int LZ_W   = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANES-1:0]        req_valid,
    output logic [LANES-1:0]        req_ready,
    input  logic [LANES*EXP_W-1:0]  req_exp,
    input  logic [LANES*LZ_W-1:0]   req_lz,
    output logic [EXP_W-1:0]        adj_exp_tmp,
    output logic [LZ_W-1:0]         adj_lz,
    input  logic [EXP_W-1:0]        adj_exp_norm,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [LANE_W-1:0]       res_lane,
    output logic [EXP_W-1:0]        res_exp,
    output logic                    res_uf
);

    logic [1:0]        count_reg;
    logic              rd_ptr_reg;
    logic              wr_ptr_reg;
    logic [LANE_W-1:0] rr_ptr_reg;
    logic [LANE_W-1:0] fifo_lane_reg [2];
    logic [EXP_W-1:0]  fifo_exp_reg  [2];

    logic [EXP_W-1:0]  lane_exp [LANES];
    logic [LZ_W-1:0]   lane_lz  [LANES];

    logic              push;
    logic              pop;
    logic              can_accept;
    logic              grant_any;
    logic [LANE_W-1:0] grant_idx;

    assign res_valid  = (count_reg != 2'd0);
    assign pop        = res_valid & res_ready;
    // A full FIFO still accepts when the head is leaving in the same cycle.
    assign can_accept = (count_reg != 2'd2) | pop;
    assign push       = grant_any;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_exp[gi]  = req_exp[gi*EXP_W +: EXP_W];
            assign lane_lz[gi]   = req_lz[gi*LZ_W +: LZ_W];
            assign req_ready[gi] = grant_any && (grant_idx == LANE_W'(gi));
        end
    endgenerate

    // Scan lanes starting at rr_ptr; index arithmetic wraps since LANES is 2^LANE_W.
    always_comb begin
        logic [LANE_W-1:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (rst_n && can_accept) begin
            for (int k = 0; k < LANES; k++) begin
                cand = rr_ptr_reg + LANE_W'(k);
                if (!grant_any && req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    assign adj_exp_tmp = grant_any ? lane_exp[grant_idx] : '0;
    assign adj_lz      = grant_any ? lane_lz[grant_idx]  : '0;

    assign res_lane = fifo_lane_reg[rd_ptr_reg];
    assign res_exp  = fifo_exp_reg[rd_ptr_reg];
    assign res_uf   = fifo_exp_reg[rd_ptr_reg][EXP_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= 2'd0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            rr_ptr_reg <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_lane_reg[i] <= '0;
                fifo_exp_reg[i]  <= '0;
            end
        end else begin
            if (push) begin
                fifo_lane_reg[wr_ptr_reg] <= grant_idx;
                fifo_exp_reg[wr_ptr_reg]  <= adj_exp_norm;
                wr_ptr_reg                <= ~wr_ptr_reg;
                rr_ptr_reg                <= grant_idx + LANE_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_norm_adj_arbiter.sv
// Directed bench for norm_adj_arbiter; the shared adjust unit is modelled here.
module tb_norm_adj_arbiter;

    localparam int LANES  = 4;
    localparam int LANE_W = 2;
    localparam int EXP_W  = 10;
    localparam int LZ_W   = 7;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [LANES-1:0]       req_valid = '0;
    logic [LANES-1:0]       req_ready;
    logic [LANES*EXP_W-1:0] req_exp = '0;
    logic [LANES*LZ_W-1:0]  req_lz = '0;
    logic [EXP_W-1:0]       adj_exp_tmp;
    logic [LZ_W-1:0]        adj_lz;
    logic [EXP_W-1:0]       adj_exp_norm;
    logic                   res_valid;
    logic                   res_ready = 1'b0;
    logic [LANE_W-1:0]      res_lane;
    logic [EXP_W-1:0]       res_exp;
    logic                   res_uf;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign adj_exp_norm = adj_exp_tmp - {{(EXP_W-LZ_W){1'b0}}, adj_lz};

    norm_adj_arbiter #(.LANES(LANES), .LANE_W(LANE_W), .EXP_W(EXP_W), .LZ_W(LZ_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_exp(req_exp), .req_lz(req_lz),
        .adj_exp_tmp(adj_exp_tmp), .adj_lz(adj_lz), .adj_exp_norm(adj_exp_norm),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_lane(res_lane), .res_exp(res_exp), .res_uf(res_uf)
    );

    task automatic set_lane(input int lane, input logic [EXP_W-1:0] e, input logic [LZ_W-1:0] lz);
        req_exp[lane*EXP_W +: EXP_W] = e;
        req_lz[lane*LZ_W +: LZ_W]    = lz;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = 4'b1111;
        res_ready = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready got=%b want=0000", req_ready); end
        total++;
        if (res_valid !== 1'b0 || res_lane !== 2'd0 || res_exp !== 10'd0 || res_uf !== 1'b0) begin
            bad++; $display("FAIL rst_res got v=%b l=%0d e=%h uf=%b want 0/0/000/0", res_valid, res_lane, res_exp, res_uf);
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: req_ready=%b res_valid=%b", req_ready, res_valid);
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        @(negedge clk);
        set_lane(2, 10'd130, 7'd5);
        req_valid = 4'b0100;
        #1;
        total++;
        if (req_ready !== 4'b0100 || adj_exp_tmp !== 10'd130 || adj_lz !== 7'd5) begin
            bad++; $display("FAIL single_grant got rdy=%b exp=%0d lz=%0d want 0100/130/5", req_ready, adj_exp_tmp, adj_lz);
        end
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        total++;
        if (res_valid !== 1'b1 || res_lane !== 2'd2 || res_exp !== 10'd125 || res_uf !== 1'b0) begin
            bad++; $display("FAIL single_res got v=%b l=%0d e=%0d uf=%b want 1/2/125/0", res_valid, res_lane, res_exp, res_uf);
        end
        @(negedge clk);
        total++;
        if (res_valid !== 1'b0) begin bad++; $display("FAIL single_drain got v=%b want 0", res_valid); end
        $display("single: lane=2 exp=130 lz=5 -> res_exp=125");
    endtask

    task automatic test_underflow();
        res_ready = 1'b1;
        @(negedge clk);
        set_lane(0, 10'd3, 7'd8);
        req_valid = 4'b0001;
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        total++;
        if (res_valid !== 1'b1 || res_lane !== 2'd0 || res_exp !== 10'h3FB || res_uf !== 1'b1) begin
            bad++; $display("FAIL underflow got v=%b l=%0d e=%h uf=%b want 1/0/3fb/1", res_valid, res_lane, res_exp, res_uf);
        end
        @(negedge clk);
        $display("underflow: exp=3 lz=8 -> res_exp=%h uf=%b", res_exp, res_uf);
    endtask

    task automatic test_round_robin();
        logic [EXP_W-1:0] want_exp;
        do_reset();
        res_ready = 1'b1;
        for (int l = 0; l < LANES; l++) set_lane(l, 10'(100 + 10*l), 7'(l));
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (k < 5) begin
                total++;
                if (req_ready !== 4'(1 << (k % 4))) begin
                    bad++; $display("FAIL rr_grant%0d got=%b want=%b", k, req_ready, 4'(1 << (k % 4)));
                end
            end
            if (k > 0) begin
                want_exp = 10'(100 + 10*((k-1) % 4) - ((k-1) % 4));
                total++;
                if (res_valid !== 1'b1 || res_lane !== 2'((k-1) % 4) || res_exp !== want_exp) begin
                    bad++; $display("FAIL rr_res%0d got v=%b l=%0d e=%0d want 1/%0d/%0d", k, res_valid, res_lane, res_exp, (k-1) % 4, want_exp);
                end
                $display("rr: cycle=%0d res_lane=%0d res_exp=%0d", k, res_lane, res_exp);
            end
            if (k < 5) begin
                @(posedge clk);
                if (k == 4) #1 req_valid = '0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [EXP_W-1:0] held;
        do_reset();
        res_ready = 1'b0;
        set_lane(1, 10'd200, 7'd3);
        set_lane(3, 10'd20, 7'd20);
        req_valid = 4'b1010;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_grant1 got=%b want=0010", req_ready); end
        @(posedge clk); #1 req_valid = 4'b1000;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_grant3 got=%b want=1000", req_ready); end
        @(posedge clk); #1;
        set_lane(1, 10'd50, 7'd1);
        req_valid = 4'b0010;
        held = res_exp;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (req_ready !== 4'b0000 || res_valid !== 1'b1 || res_lane !== 2'd1 || res_exp !== 10'd197 || res_exp !== held) begin
                bad++; $display("FAIL bp_hold%0d got rdy=%b v=%b l=%0d e=%0d want 0000/1/1/197", c, req_ready, res_valid, res_lane, res_exp);
            end
            $display("bp: hold cycle=%0d res_lane=%0d req_ready=%b", c, res_lane, req_ready);
        end
        res_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_full_pop_grant got=%b want=0010", req_ready); end
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        total++;
        if (res_valid !== 1'b1 || res_lane !== 2'd3 || res_exp !== 10'd0) begin
            bad++; $display("FAIL bp_drain3 got v=%b l=%0d e=%0d want 1/3/0", res_valid, res_lane, res_exp);
        end
        @(negedge clk);
        total++;
        if (res_valid !== 1'b1 || res_lane !== 2'd1 || res_exp !== 10'd49) begin
            bad++; $display("FAIL bp_drain1b got v=%b l=%0d e=%0d want 1/1/49", res_valid, res_lane, res_exp);
        end
        @(negedge clk);
        total++;
        if (res_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got v=%b want 0", res_valid); end
        $display("bp: drained lanes 1,3,1");
    endtask

    task automatic test_reset_mid();
        do_reset();
        res_ready = 1'b0;
        set_lane(0, 10'd40, 7'd0);
        set_lane(2, 10'd60, 7'd0);
        set_lane(3, 10'd70, 7'd0);
        req_valid = 4'b0101;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        total++;
        if (res_valid !== 1'b1 || req_ready !== 4'b0000) begin
            bad++; $display("FAIL mid_full got v=%b rdy=%b want 1/0000", res_valid, req_ready);
        end
        req_valid = 4'b1100;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (res_valid !== 1'b0 || req_ready !== 4'b0000) begin
            bad++; $display("FAIL mid_async got v=%b rdy=%b want 0/0000", res_valid, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin bad++; $display("FAIL mid_first_grant got=%b want=0100", req_ready); end
        @(posedge clk); #1 req_valid = '0;
        res_ready = 1'b1;
        @(negedge clk);
        $display("reset_mid: post-reset grant lane=%0d", res_lane);
    endtask

    task automatic test_idle();
        res_ready = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (req_ready !== 4'b0000 || adj_exp_tmp !== 10'd0 || adj_lz !== 7'd0 || res_valid !== 1'b0) begin
                bad++; $display("FAIL idle%0d got rdy=%b exp=%0d lz=%0d v=%b want 0", c, req_ready, adj_exp_tmp, adj_lz, res_valid);
            end
        end
        req_valid = 4'b1001;
        #1;
        total++;
        if (req_ready !== 4'b1000) begin bad++; $display("FAIL idle_rr_kept got=%b want=1000", req_ready); end
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        $display("idle: 10 cycles, next grant lane=%0d", res_lane);
    endtask

    initial begin
        #20000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_underflow();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
